param_seq_divider: RTL and testbench

Parametrised restoring divider that pairs an iteration-counter controller with its own shift/subtract datapath. It generalises the team's fixed 6-iteration, 3-states-per-bit divider controller to any operand width, at one quotient bit per clock. It also adds divide-by-zero detection, registered quotient and remainder outputs, and busy/done handshaking. It sits beside the arithmetic units as a multi-cycle unsigned divide engine.

---
 rtl/param_seq_divider.sv | 156 +++++++++++++++
 tb/tb_param_seq_divider.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_seq_divider.sv
// ---------------------------------------------------------------------------
// param_seq_divider
//
// Multi-cycle unsigned restoring divider. It resolves one quotient bit per
// clock and detects a zero divisor up front. Results are registered and held
// until the next operation completes.
//
// Parameters:
//   WIDTH  operand / quotient / remainder width in bits (>= 2)
//   CNT_W  iteration counter width
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request; operands are captured on the first edge seen in IDLE
//   dividend     unsigned dividend
//   divisor      unsigned divisor
//   quotient     registered quotient of the last completed operation
//   remainder    registered remainder of the last completed operation
//   busy         high while an operation is in flight (WAIT_REL/CHECK/ITER)
//   done         one-cycle completion pulse
//   div_by_zero  registered flag of the last result, valid with done
// ---------------------------------------------------------------------------
module param_seq_divider #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REL,
    CHECK,
    ITER,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH+1:0] s_ext;
  logic [WIDTH+1:0] t_ext;
  logic             bit_ok;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic             last_iter;

  // One restoring step. The subtraction is carried one bit wider than A so
  // the top bit is a clean borrow. Because A < D holds between steps, this
  // borrow equals bit WIDTH of a WIDTH+1-bit difference.
  always_comb begin
    s_ext     = {a, q[WIDTH-1]};
    t_ext     = s_ext - {2'b00, d};
    bit_ok    = ~t_ext[WIDTH+1];
    a_next    = bit_ok ? t_ext[WIDTH:0] : s_ext[WIDTH:0];
    q_next    = {q[WIDTH-2:0], bit_ok};
    last_iter = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = WAIT_REL;
      end
      WAIT_REL: begin
        busy = 1'b1;
        // Hold here until start drops so a long request is captured only once.
        if (!start) state_next = CHECK;
      end
      CHECK: begin
        busy       = 1'b1;
        state_next = (d == '0) ? DONE : ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q   <= dividend;
            d   <= divisor;
            a   <= '0;
            cnt <= '0;
          end
        end
        CHECK: begin
          // Zero divisor: report all-ones quotient and pass the dividend through.
          if (d == '0) begin
            quotient    <= '1;
            remainder   <= q;
            div_by_zero <= 1'b1;
          end
        end
        ITER: begin
          a   <= a_next;
          q   <= q_next;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            quotient    <= q_next;
            remainder   <= a_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_param_seq_divider
//
// Self-checking bench for param_seq_divider. It instantiates an 8-bit and a
// 16-bit divider. An arithmetic model (/ and %) predicts each result and its
// completion cycle. One negedge process compares the outputs, busy and done
// of both instances every cycle. Literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_param_seq_divider;

  logic        clk;
  logic        rst;

  logic        start8;
  logic [7:0]  dividend8, divisor8, quotient8, remainder8;
  logic        busy8, done8, dz8;

  logic        start16;
  logic [15:0] dividend16, divisor16, quotient16, remainder16;
  logic        busy16, done16, dz16;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          cap;
    int          due;
  } exp_t;

  exp_t expq[2][$];
  exp_t last[2];
  int   doneCyc[2];
  int   lastCap[2];
  int   cyc;
  int   tests;
  int   errors;

  param_seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .dividend(dividend8), .divisor(divisor8),
    .quotient(quotient8), .remainder(remainder8),
    .busy(busy8), .done(done8), .div_by_zero(dz8)
  );

  param_seq_divider #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16),
    .dividend(dividend16), .divisor(divisor16),
    .quotient(quotient16), .remainder(remainder16),
    .busy(busy16), .done(done16), .div_by_zero(dz16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Result and completion cycle of one operation, from the arithmetic rules.
  function automatic exp_t model(input int k, input logic [15:0] dd,
                                 input logic [15:0] dv, input int cap,
                                 input int hold);
    exp_t e;
    int   w;
    w     = (k == 1) ? 16 : 8;
    e.cap = cap;
    if (dv == 16'd0) begin
      e.q   = (k == 1) ? 16'hFFFF : 16'h00FF;
      e.r   = dd;
      e.dz  = 1'b1;
      e.due = cap + 2 + (hold - 1);
    end else begin
      e.q   = dd / dv;
      e.r   = dd % dv;
      e.dz  = 1'b0;
      e.due = cap + w + 2 + (hold - 1);
    end
    return e;
  endfunction

  task automatic clearModel();
    for (int k = 0; k < 2; k++) begin
      expq[k].delete();
      last[k].q  = '0;
      last[k].r  = '0;
      last[k].dz = 1'b0;
    end
  endtask

  task automatic compareCycle(input int k, input logic isDone, input logic isBusy,
                              input logic [15:0] qv, input logic [15:0] rv,
                              input logic dzv);
    exp_t e;
    logic busyExp;
    if (expq[k].size() > 0 && cyc > expq[k][0].due) begin
      tests++;
      errors++;
      $display("[TB] FAIL late_done[%0d]: no done by cycle %0d, expected at %0d",
               k, cyc, expq[k][0].due);
      e = expq[k].pop_front();
    end
    if (isDone) begin
      if (expq[k].size() == 0) begin
        tests++;
        errors++;
        $display("[TB] FAIL unexpected_done[%0d]: got done=1 at cycle %0d, expected 0", k, cyc);
      end else begin
        e = expq[k].pop_front();
        checkOutput($sformatf("quotient[%0d]", k), {16'h0, qv}, {16'h0, e.q});
        checkOutput($sformatf("remainder[%0d]", k), {16'h0, rv}, {16'h0, e.r});
        checkOutput($sformatf("div_by_zero[%0d]", k), {31'h0, dzv}, {31'h0, e.dz});
        checkOutput($sformatf("done_cycle[%0d]", k), cyc, e.due);
        checkOutput($sformatf("busy_at_done[%0d]", k), {31'h0, isBusy}, 32'd0);
        last[k]    = e;
        doneCyc[k] = cyc;
      end
    end else begin
      checkOutput($sformatf("hold_quotient[%0d]", k), {16'h0, qv}, {16'h0, last[k].q});
      checkOutput($sformatf("hold_remainder[%0d]", k), {16'h0, rv}, {16'h0, last[k].r});
      checkOutput($sformatf("hold_dz[%0d]", k), {31'h0, dzv}, {31'h0, last[k].dz});
      busyExp = (expq[k].size() > 0) && (cyc >= expq[k][0].cap);
      checkOutput($sformatf("busy[%0d]", k), {31'h0, isBusy}, {31'h0, busyExp});
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      compareCycle(0, done8, busy8, {8'h0, quotient8}, {8'h0, remainder8}, dz8);
      compareCycle(1, done16, busy16, quotient16, remainder16, dz16);
    end
  end

  // Drive one request on instance k with start held for 'hold' clock edges.
  task automatic applyStimulus(input int k, input logic [15:0] dd,
                               input logic [15:0] dv, input int hold);
    @(negedge clk);
    if (k == 0) begin
      start8 = 1'b1; dividend8 = dd[7:0]; divisor8 = dv[7:0];
    end else begin
      start16 = 1'b1; dividend16 = dd; divisor16 = dv;
    end
    lastCap[k] = cyc + 1;
    expq[k].push_back(model(k, dd, dv, cyc + 1, hold));
    repeat (hold) @(negedge clk);
    if (k == 0) start8 = 1'b0;
    else        start16 = 1'b0;
  endtask

  task automatic waitResult(input int k, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (expq[k].size() == 0) break;
    end
    if (expq[k].size() != 0) begin
      tests++;
      errors++;
      $display("[TB] FAIL timeout[%0d]: result pending after %0d cycles, expected done", k, budget);
      expq[k].delete();
    end
  endtask

  initial begin : stim
    logic [15:0] dd, dv;
    logic [31:0] recon;
    int          cap;
    tests   = 0;
    errors  = 0;
    rst     = 1'b1;
    start8  = 1'b0; dividend8  = '0; divisor8  = '0;
    start16 = 1'b0; dividend16 = '0; divisor16 = '0;
    doneCyc = '{0, 0};
    lastCap = '{0, 0};
    clearModel();

    // Reset state.
    #1;
    checkOutput("reset_busy8", {31'h0, busy8}, 32'd0);
    checkOutput("reset_done8", {31'h0, done8}, 32'd0);
    checkOutput("reset_quotient8", {24'h0, quotient8}, 32'd0);
    checkOutput("reset_remainder8", {24'h0, remainder8}, 32'd0);
    checkOutput("reset_dz8", {31'h0, dz8}, 32'd0);
    checkOutput("reset_busy16", {31'h0, busy16}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // 100 / 7 with a one-cycle start pulse.
    applyStimulus(0, 16'd100, 16'd7, 1);
    waitResult(0, 30);
    checkOutput("q_100_7", {24'h0, quotient8}, 32'd14);
    checkOutput("r_100_7", {24'h0, remainder8}, 32'd2);
    checkOutput("lat_100_7", doneCyc[0] - lastCap[0], 32'd10);

    // Divide by zero, then a normal divide back-to-back clears the flag.
    applyStimulus(0, 16'd77, 16'd0, 1);
    waitResult(0, 30);
    checkOutput("q_77_0", {24'h0, quotient8}, 32'd255);
    checkOutput("r_77_0", {24'h0, remainder8}, 32'd77);
    checkOutput("dz_77_0", {31'h0, dz8}, 32'd1);
    checkOutput("lat_77_0", doneCyc[0] - lastCap[0], 32'd2);
    applyStimulus(0, 16'd5, 16'd9, 1);
    waitResult(0, 30);
    checkOutput("q_5_9", {24'h0, quotient8}, 32'd0);
    checkOutput("r_5_9", {24'h0, remainder8}, 32'd5);
    checkOutput("dz_5_9", {31'h0, dz8}, 32'd0);

    // Start held 4 cycles; operands change on the 2nd held cycle.
    @(negedge clk);
    start8 = 1'b1; dividend8 = 8'd255; divisor8 = 8'd1;
    cap = cyc + 1;
    expq[0].push_back(model(0, 16'd255, 16'd1, cap, 4));
    @(negedge clk);
    dividend8 = 8'd3; divisor8 = 8'd3;
    repeat (3) @(negedge clk);
    start8 = 1'b0;
    waitResult(0, 30);
    checkOutput("q_255_1", {24'h0, quotient8}, 32'd255);
    checkOutput("r_255_1", {24'h0, remainder8}, 32'd0);
    checkOutput("lat_255_1", doneCyc[0] - cap, 32'd13);

    // start re-asserted mid-ITER and during DONE must be ignored.
    applyStimulus(0, 16'd50, 16'd6, 1);
    repeat (4) @(negedge clk);
    start8 = 1'b1; dividend8 = 8'd200; divisor8 = 8'd3;
    repeat (2) @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (done8) break;
    end
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    checkOutput("q_50_6", {24'h0, quotient8}, 32'd8);
    checkOutput("r_50_6", {24'h0, remainder8}, 32'd2);
    checkOutput("idle_after_ignored", {31'h0, busy8}, 32'd0);
    checkOutput("pending_after_ignored", expq[0].size(), 32'd0);

    // Asynchronous reset between edges while iterating.
    applyStimulus(0, 16'd120, 16'd7, 1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    clearModel();
    #1;
    checkOutput("abort_busy", {31'h0, busy8}, 32'd0);
    checkOutput("abort_done", {31'h0, done8}, 32'd0);
    checkOutput("abort_quotient", {24'h0, quotient8}, 32'd0);
    checkOutput("abort_remainder", {24'h0, remainder8}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    applyStimulus(0, 16'd200, 16'd13, 1);
    waitResult(0, 30);
    checkOutput("q_200_13", {24'h0, quotient8}, 32'd15);
    checkOutput("r_200_13", {24'h0, remainder8}, 32'd5);
    checkOutput("lat_200_13", doneCyc[0] - lastCap[0], 32'd10);

    // 16-bit instance.
    applyStimulus(1, 16'd65535, 16'd255, 1);
    waitResult(1, 40);
    checkOutput("q_65535_255", {16'h0, quotient16}, 32'd257);
    checkOutput("r_65535_255", {16'h0, remainder16}, 32'd0);
    checkOutput("lat_65535_255", doneCyc[1] - lastCap[1], 32'd18);

    // Back-to-back random operands, checking the division identity.
    for (int i = 0; i < 1000; i++) begin
      dd = 16'($urandom);
      if ($urandom_range(0, 3) == 0) dv = 16'($urandom_range(0, 20));
      else                           dv = 16'($urandom);
      applyStimulus(1, dd, dv, 1);
      waitResult(1, 40);
      if (dv != 16'd0) begin
        recon = 32'(quotient16) * 32'(dv) + 32'(remainder16);
        checkOutput("invariant", recon, {16'h0, dd});
        checkOutput("rem_lt_div", {31'h0, (remainder16 < dv)}, 32'd1);
      end else begin
        checkOutput("rand_dz", {31'h0, dz16}, 32'd1);
      end
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
